// File: rtl/asip_pkg.sv
// Shared types for the vector ASIP front end: fetch FSM states and the IF/ID bundle.
package asip_pkg;

    localparam int OP_W   = 2;
    localparam int INST_W = 2;
    localparam int AW_DEF = 16;
    localparam int IW_DEF = 32;

    typedef enum logic {
        FS_REQ,
        FS_HOLD
    } fetch_state_e;

    // Sized by the default widths; fetch_stage casts into and out of it.
    typedef struct packed {
        logic [IW_DEF-1:0] instr;
        logic [OP_W-1:0]   op;
        logic [INST_W-1:0] inst;
        logic [AW_DEF-1:0] pc;
    } if_bundle_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads imem over req/ack, hands one pre-split
// instruction to decode over valid/ready, and squashes fetches on a taken jump.
module fetch_stage
    import asip_pkg::*;
#(
    parameter int            AW     = AW_DEF,
    parameter int            IW     = IW_DEF,
    parameter logic [AW-1:0] RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              imem_req,
    output logic [AW-1:0]     imem_addr,
    input  logic              imem_ack,
    input  logic [IW-1:0]     imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [IW-1:0]     if_instr,
    output logic [OP_W-1:0]   if_op,
    output logic [INST_W-1:0] if_inst,
    output logic [AW-1:0]     if_pc,
    input  logic              br_valid,
    input  logic              br_cond,
    input  logic              br_flag,
    input  logic [AW-1:0]     br_target
);

    function automatic logic redirectTaken(input logic v, input logic c, input logic f);
        return v & (~c | f);
    endfunction

    fetch_state_e state, stateNext;
    logic [AW-1:0] pc, pcNext;
    logic [AW-1:0] tgt, tgtNext;
    logic          kill, killNext;
    if_bundle_t    ifReg_p1, ifRegNext;
    logic          vld_p1, vldNext;
    logic          take;
    logic          reqOpen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FS_REQ;
            pc       <= RST_PC;
            tgt      <= RST_PC;
            kill     <= 1'b0;
            ifReg_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            state    <= stateNext;
            pc       <= pcNext;
            tgt      <= tgtNext;
            kill     <= killNext;
            ifReg_p1 <= ifRegNext;
            vld_p1   <= vldNext;
        end
    end

    always_comb begin
        stateNext = state;
        pcNext    = pc;
        tgtNext   = tgt;
        killNext  = kill;
        ifRegNext = ifReg_p1;
        vldNext   = vld_p1;
        take      = redirectTaken(br_valid, br_cond, br_flag);
        reqOpen   = run | kill;
        case (state)
            FS_REQ: begin
                if (reqOpen) begin
                    if (imem_ack) begin
                        if (kill || take) begin
                            // Wrong-path word: drop it and restart at the redirect target.
                            pcNext   = take ? br_target : tgt;
                            killNext = 1'b0;
                        end else begin
                            ifRegNext.instr = IW_DEF'(imem_rdata);
                            ifRegNext.op    = imem_rdata[IW-1 -: OP_W];
                            ifRegNext.inst  = imem_rdata[IW-1-OP_W -: INST_W];
                            ifRegNext.pc    = AW_DEF'(pc);
                            vldNext         = 1'b1;
                            stateNext       = FS_HOLD;
                        end
                    end else if (take) begin
                        // Address must stay put until the open request completes.
                        killNext = 1'b1;
                        tgtNext  = br_target;
                    end
                end else if (take) begin
                    pcNext = br_target;
                end
            end
            FS_HOLD: begin
                if (take) begin
                    pcNext    = br_target;
                    vldNext   = 1'b0;
                    stateNext = FS_REQ;
                end else if (if_ready) begin
                    pcNext    = AW'(ifReg_p1.pc) + AW'(1);
                    vldNext   = 1'b0;
                    stateNext = FS_REQ;
                end
            end
            default: stateNext = FS_REQ;
        endcase
    end

    // rst_n gates the request so it drops without waiting for a clock.
    assign imem_req  = rst_n & (state == FS_REQ) & (run | kill);
    assign imem_addr = pc;
    assign if_valid  = vld_p1;
    assign if_instr  = IW'(ifReg_p1.instr);
    assign if_op     = ifReg_p1.op;
    assign if_inst   = ifReg_p1.inst;
    assign if_pc     = AW'(ifReg_p1.pc);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: behavioural imem with programmable ack
// delay, expected PCs queued by the stimulus and checked on each decode accept.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [1:0]  if_op;
    logic [1:0]  if_inst;
    logic [15:0] if_pc;
    logic        br_valid;
    logic        br_cond;
    logic        br_flag;
    logic [15:0] br_target;

    int          nTests = 0;
    int          nFail  = 0;
    int          ackDelay = 0;
    int          memCnt;
    logic [15:0] expQ[$];
    logic [15:0] monPc;
    logic [31:0] monW;

    fetch_stage #(.AW(16), .IW(32), .RST_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_op(if_op),
        .if_inst(if_inst), .if_pc(if_pc),
        .br_valid(br_valid), .br_cond(br_cond), .br_flag(br_flag), .br_target(br_target)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [15:0] a);
        return {a[7:4], 12'h000, a};
    endfunction

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Instruction memory: acks once per request after ackDelay extra cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_ack   <= 1'b0;
            imem_rdata <= '0;
            memCnt     <= 0;
        end else begin
            imem_ack <= 1'b0;
            if (imem_req && !imem_ack) begin
                if (memCnt >= ackDelay) begin
                    imem_ack   <= 1'b1;
                    imem_rdata <= memWord(imem_addr);
                    memCnt     <= 0;
                end else begin
                    memCnt <= memCnt + 1;
                end
            end
        end
    end

    // Decode-side monitor: every accepted, non-squashed instruction pops one expectation.
    always @(negedge clk) begin
        if (rst_n && if_valid && if_ready && !(br_valid && (!br_cond || br_flag))) begin
            if (expQ.size() == 0) begin
                checkEq("unexpectedAccept", 64'(if_pc), 64'hDEAD);
            end else begin
                monPc = expQ.pop_front();
                monW  = memWord(monPc);
                checkEq("acceptPc", 64'(if_pc), 64'(monPc));
                checkEq("acceptInstr", 64'(if_instr), 64'(monW));
                checkEq("acceptOp", 64'(if_op), 64'(monW[31:30]));
                checkEq("acceptInst", 64'(if_inst), 64'(monW[29:28]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReq();
        int n = 0;
        while (!imem_req && n < 50) begin
            tick();
            n++;
        end
        checkEq("reqSeen", 64'(imem_req), 64'h1);
    endtask

    task automatic park();
        int n = 0;
        if_ready = 1'b0;
        while (!if_valid && n < 50) begin
            tick();
            n++;
        end
        checkEq("parkValid", 64'(if_valid), 64'h1);
    endtask

    task automatic readyPulse();
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        checkEq("drained", 64'(expQ.size()), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        logic sawValid;
        rst_n = 1'b0; run = 1'b0; if_ready = 1'b0;
        br_valid = 1'b0; br_cond = 1'b0; br_flag = 1'b0; br_target = '0;
        repeat (3) tick();
        checkEq("rstReq", 64'(imem_req), 64'h0);
        checkEq("rstValid", 64'(if_valid), 64'h0);
        checkEq("rstInstr", 64'(if_instr), 64'h0);
        checkEq("rstPc", 64'(if_pc), 64'h0);
        checkEq("rstOpInst", 64'({if_op, if_inst}), 64'h0);

        // Streaming fetch with ready held high.
        expQ.push_back(16'h0000); expQ.push_back(16'h0001); expQ.push_back(16'h0002);
        rst_n = 1'b1; run = 1'b1; if_ready = 1'b1;
        #1;
        checkEq("firstReqAddr", 64'({imem_req, imem_addr}), 64'h1_0000);
        k = 0;
        while (!if_valid && k < 20) begin
            tick();
            k++;
        end
        checkEq("firstLatency", 64'(k), 64'd2);
        waitDrain();
        if_ready = 1'b0;

        // Decode stall in HOLD.
        park();
        for (int i = 0; i < 5; i++) begin
            checkEq("stallPc", 64'(if_pc), 64'h3);
            checkEq("stallInstr", 64'(if_instr), 64'(memWord(16'h3)));
            checkEq("stallReq", 64'(imem_req), 64'h0);
            tick();
        end
        expQ.push_back(16'h0003);
        readyPulse();
        waitReq();
        checkEq("afterStallAddr", 64'(imem_addr), 64'h4);

        // Slow ack with a redirect during the wait.
        park();
        expQ.push_back(16'h0004);
        ackDelay = 4;
        readyPulse();
        checkEq("slowReq", 64'({imem_req, imem_addr}), 64'h1_0005);
        tick();
        br_valid = 1'b1; br_cond = 1'b0; br_target = 16'h0040;
        tick();
        br_valid = 1'b0;
        checkEq("addrHeld", 64'({imem_req, imem_addr}), 64'h1_0005);
        sawValid = 1'b0;
        k = 0;
        while (!(imem_req && imem_addr == 16'h0040) && k < 30) begin
            tick();
            sawValid = sawValid | if_valid;
            k++;
        end
        ackDelay = 0;
        checkEq("squashNoValid", 64'(sawValid), 64'h0);
        checkEq("redirectAddr", 64'(imem_addr), 64'h40);

        // Not-taken conditional jump in HOLD, then a taken one.
        park();
        checkEq("parkPc40", 64'(if_pc), 64'h40);
        expQ.push_back(16'h0040);
        br_valid = 1'b1; br_cond = 1'b1; br_flag = 1'b0; br_target = 16'h0080;
        readyPulse();
        br_valid = 1'b0;
        waitReq();
        checkEq("notTakenAddr", 64'(imem_addr), 64'h41);
        park();
        checkEq("parkPc41", 64'(if_pc), 64'h41);
        br_valid = 1'b1; br_cond = 1'b1; br_flag = 1'b1; br_target = 16'h0080;
        readyPulse();
        br_valid = 1'b0; br_flag = 1'b0;
        waitReq();
        checkEq("takenAddr", 64'(imem_addr), 64'h80);

        // PC wrap from 0xFFFF.
        park();
        br_valid = 1'b1; br_cond = 1'b0; br_target = 16'hFFFF;
        tick();
        br_valid = 1'b0;
        waitReq();
        checkEq("jumpTopAddr", 64'(imem_addr), 64'hFFFF);
        park();
        expQ.push_back(16'hFFFF);
        readyPulse();
        waitReq();
        checkEq("wrapAddr", 64'(imem_addr), 64'h0);

        // Reset while a request is open.
        park();
        expQ.push_back(16'h0000);
        ackDelay = 3;
        readyPulse();
        checkEq("preRstReq", 64'({imem_req, imem_addr}), 64'h1_0001);
        tick();
        #2 rst_n = 1'b0;
        #1;
        checkEq("midRstReq", 64'(imem_req), 64'h0);
        checkEq("midRstValid", 64'(if_valid), 64'h0);
        checkEq("midRstPc", 64'(if_pc), 64'h0);
        tick();
        rst_n = 1'b1;
        ackDelay = 0;
        #1;
        checkEq("postRstReq", 64'({imem_req, imem_addr}), 64'h1_0000);
        park();
        checkEq("postRstPc", 64'(if_pc), 64'h0);

        // run=0: accepted instruction, but no new request issued.
        run = 1'b0;
        expQ.push_back(16'h0000);
        readyPulse();
        for (int i = 0; i < 3; i++) begin
            checkEq("idleReq", 64'(imem_req), 64'h0);
            tick();
        end
        checkEq("idlePcHeld", 64'(imem_addr), 64'h1);
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
